// File: rtl/shift_ex_stage_pkg.sv
// Shared definitions for the shift execute stage: MIPS funct codes,
// Shifter type codes and the funct decoder.
package shift_ex_stage_pkg;

   localparam logic [5:0] FUNCT_SLL  = 6'h00;
   localparam logic [5:0] FUNCT_SRL  = 6'h02;
   localparam logic [5:0] FUNCT_SRA  = 6'h03;
   localparam logic [5:0] FUNCT_SLLV = 6'h04;
   localparam logic [5:0] FUNCT_SRLV = 6'h06;
   localparam logic [5:0] FUNCT_SRAV = 6'h07;

   typedef enum logic [1:0] {
      SH_SLL  = 2'b00,
      SH_PASS = 2'b01,
      SH_SRL  = 2'b10,
      SH_SRA  = 2'b11
   } sh_type_e;

   typedef struct packed {
      sh_type_e sh_type;
      logic     var_amt;
      logic     illegal;
   } decode_t;

   typedef struct packed {
      logic [31:0] result;
      logic [4:0]  rd;
      logic        we;
      logic        illegal;
   } slot_t;

   // Unknown funct falls through to pass-through so the Shifter returns rt.
   function automatic decode_t decode_funct(input logic [5:0] funct);
      decode_t d;
      d = '{sh_type: SH_PASS, var_amt: 1'b0, illegal: 1'b1};
      case (funct)
         FUNCT_SLL:  d = '{sh_type: SH_SLL, var_amt: 1'b0, illegal: 1'b0};
         FUNCT_SRL:  d = '{sh_type: SH_SRL, var_amt: 1'b0, illegal: 1'b0};
         FUNCT_SRA:  d = '{sh_type: SH_SRA, var_amt: 1'b0, illegal: 1'b0};
         FUNCT_SLLV: d = '{sh_type: SH_SLL, var_amt: 1'b1, illegal: 1'b0};
         FUNCT_SRLV: d = '{sh_type: SH_SRL, var_amt: 1'b1, illegal: 1'b0};
         FUNCT_SRAV: d = '{sh_type: SH_SRA, var_amt: 1'b1, illegal: 1'b0};
         default: ;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/shift_ex_stage_if.sv
// ID/EX input and EX/MEM output handshake bundle of the shift execute stage.
interface shift_ex_stage_if;

   logic        in_valid;
   logic        in_ready;
   logic [5:0]  in_funct;
   logic [4:0]  in_shamt;
   logic [31:0] in_rs;
   logic [31:0] in_rt;
   logic [4:0]  in_rd;

   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic [4:0]  out_rd;
   logic        out_we;
   logic        out_illegal;

   modport slave (
      input  in_valid, in_funct, in_shamt, in_rs, in_rt, in_rd, out_ready,
      output in_ready, out_valid, out_result, out_rd, out_we, out_illegal
   );

   modport master (
      output in_valid, in_funct, in_shamt, in_rs, in_rt, in_rd, out_ready,
      input  in_ready, out_valid, out_result, out_rd, out_we, out_illegal
   );

endinterface

// File: rtl/shift_ex_stage_shifter.sv
// Barrel shifter: logical left/right, arithmetic right, or pass-through.
module shift_ex_stage_shifter
   import shift_ex_stage_pkg::*;
(
   input  logic [1:0]  funct,
   input  logic [31:0] a,
   input  logic [4:0]  n,
   output logic [31:0] r
);

   always_comb begin
      r = a;
      unique case (sh_type_e'(funct))
         SH_SLL:  r = a << n;
         SH_SRL:  r = a >> n;
         SH_SRA:  r = 32'($signed(a) >>> n);
         SH_PASS: r = a;
      endcase
   end

endmodule

// File: rtl/shift_ex_stage.sv
// Execute-stage slot for MIPS R-type shifts: decode, one Shifter, and an
// output register backed by a one-entry skid buffer.
module shift_ex_stage
   import shift_ex_stage_pkg::*;
#(
   parameter int unsigned COUNT_W = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               flush,
   shift_ex_stage_if.slave    bus,
   output logic [COUNT_W-1:0] shift_count
);

   decode_t     dec;
   logic [4:0]  amt;
   logic [31:0] sh_r;
   slot_t       new_slot;
   slot_t       or_q;
   slot_t       sk_q;
   logic        out_valid_q;
   logic        sk_valid;
   logic        in_ready_q;
   logic        accept;
   logic        or_free;

   always_comb begin
      dec      = decode_funct(bus.in_funct);
      amt      = dec.var_amt ? bus.in_rs[4:0] : bus.in_shamt;
      new_slot = '{result:  sh_r,
                   rd:      bus.in_rd,
                   we:      !dec.illegal && (bus.in_rd != 5'd0),
                   illegal: dec.illegal};
   end

   shift_ex_stage_shifter u_shifter (
      .funct (dec.sh_type),
      .a     (bus.in_rt),
      .n     (amt),
      .r     (sh_r)
   );

   assign accept  = bus.in_valid && in_ready_q;
   assign or_free = !out_valid_q || bus.out_ready;

   // in_ready is only ever low while SK holds an op, so an accept never
   // coincides with SK draining into OR.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         or_q        <= '0;
         sk_q        <= '0;
         out_valid_q <= 1'b0;
         sk_valid    <= 1'b0;
         in_ready_q  <= 1'b0;
         shift_count <= '0;
      end else begin
         if (out_valid_q && bus.out_ready)
            shift_count <= shift_count + 1'b1;

         if (flush) begin
            out_valid_q <= 1'b0;
            sk_valid    <= 1'b0;
            in_ready_q  <= 1'b1;
         end else if (or_free) begin
            if (sk_valid) begin
               or_q        <= sk_q;
               out_valid_q <= 1'b1;
               sk_valid    <= 1'b0;
            end else begin
               out_valid_q <= accept;
               if (accept)
                  or_q <= new_slot;
            end
            in_ready_q <= 1'b1;
         end else begin
            if (accept) begin
               sk_q     <= new_slot;
               sk_valid <= 1'b1;
            end
            in_ready_q <= !(sk_valid || accept);
         end
      end
   end

   assign bus.in_ready    = in_ready_q;
   assign bus.out_valid   = out_valid_q;
   assign bus.out_result  = or_q.result;
   assign bus.out_rd      = or_q.rd;
   assign bus.out_we      = or_q.we;
   assign bus.out_illegal = or_q.illegal;

endmodule
